// File: rtl/wb_arbiter.sv
// wb_arbiter: per-port writeback FIFOs merged onto one scoreboard port by a round-robin arbiter.
// Optional stall counter is built only when WB_ARBITER_PERF_EN is defined.
module wb_arbiter #(
   parameter int NR_PORTS      = 4,
   parameter int DEPTH         = 2,
   parameter int TRANS_ID_BITS = 3,
   parameter int EXC_BITS      = 129
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   flush_i,
   input  logic [NR_PORTS-1:0]                    valid_i,
   input  logic [NR_PORTS-1:0][TRANS_ID_BITS-1:0] trans_id_i,
   input  logic [NR_PORTS-1:0][63:0]              result_i,
   input  logic [NR_PORTS-1:0][EXC_BITS-1:0]      exception_i,
   output logic [NR_PORTS-1:0]                    port_ready_o,
   output logic                                   wb_valid_o,
   input  logic                                   wb_ready_i,
   output logic [TRANS_ID_BITS-1:0]               wb_trans_id_o,
   output logic [63:0]                            wb_result_o,
   output logic [EXC_BITS-1:0]                    wb_exception_o,
   output logic                                   overflow_o,
   output logic [31:0]                            stall_cnt_o
);
   localparam int PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int EW = TRANS_ID_BITS + 64 + EXC_BITS;

   logic [EW-1:0]       r_mem    [NR_PORTS][DEPTH];
   logic [AW-1:0]       r_rd_ptr [NR_PORTS];
   logic [AW-1:0]       r_wr_ptr [NR_PORTS];
   logic [CW-1:0]       r_cnt    [NR_PORTS];
   logic [PW-1:0]       r_rr_ptr;
   logic [PW-1:0]       r_grant;
   logic                r_hold;
   logic                r_overflow;

   logic [NR_PORTS-1:0] w_nonempty;
   logic [NR_PORTS-1:0] w_full;
   logic [NR_PORTS-1:0] w_push;
   logic [NR_PORTS-1:0] w_pop;
   logic [NR_PORTS-1:0] w_drop;
   logic [PW-1:0]       w_search;
   logic [PW-1:0]       w_grant;
   logic                w_found;
   logic                w_fire;
   int                  w_idx;
   logic [EW-1:0]       w_head;

   // FIFO occupancy flags
   always_comb begin
      for (int i = 0; i < NR_PORTS; i++) begin
         w_nonempty[i]   = (r_cnt[i] != {CW{1'b0}});
         w_full[i]       = (r_cnt[i] == CW'(DEPTH));
         port_ready_o[i] = (r_cnt[i] <= CW'(DEPTH - 2));
      end
   end

   // Round-robin search: first non-empty port at or after r_rr_ptr
   always_comb begin
      w_search = r_rr_ptr;
      w_found  = 1'b0;
      w_idx    = 0;
      for (int k = 0; k < NR_PORTS; k++) begin
         w_idx = int'(r_rr_ptr) + k;
         w_idx = (w_idx >= NR_PORTS) ? (w_idx - NR_PORTS) : w_idx;
         if (!w_found && w_nonempty[w_idx]) begin
            w_found  = 1'b1;
            w_search = PW'(w_idx);
         end else begin
            w_found  = w_found;
         end
      end
   end

   // A stalled grant is frozen so late arrivals cannot steal the bus mid-handshake
   assign w_grant    = r_hold ? r_grant : w_search;
   assign wb_valid_o = |w_nonempty;
   assign w_fire     = wb_valid_o & wb_ready_i;
   assign w_head     = r_mem[w_grant][r_rd_ptr[w_grant]];
   assign {wb_trans_id_o, wb_result_o, wb_exception_o} = wb_valid_o ? w_head : {EW{1'b0}};
   assign overflow_o = r_overflow;

   // Per-port push/pop/drop decisions; a popped full FIFO can still accept
   always_comb begin
      for (int i = 0; i < NR_PORTS; i++) begin
         w_pop[i]  = w_fire && (w_grant == PW'(i));
         w_push[i] = valid_i[i] && !flush_i && (!w_full[i] || w_pop[i]);
         w_drop[i] = valid_i[i] && !flush_i && w_full[i] && !w_pop[i];
      end
   end

   // FIFO pointers and counts
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NR_PORTS; i++) begin
            r_rd_ptr[i] <= {AW{1'b0}};
            r_wr_ptr[i] <= {AW{1'b0}};
            r_cnt[i]    <= {CW{1'b0}};
         end
      end else begin
         for (int i = 0; i < NR_PORTS; i++) begin
            if (flush_i) begin
               r_rd_ptr[i] <= {AW{1'b0}};
               r_wr_ptr[i] <= {AW{1'b0}};
               r_cnt[i]    <= {CW{1'b0}};
            end else begin
               if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
               if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
               r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
            end
         end
      end
   end

   // FIFO storage (no reset needed: guarded by counts)
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NR_PORTS; i++) begin
         if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= {trans_id_i[i], result_i[i], exception_i[i]};
      end
   end

   // Arbiter pointer, grant lock and sticky overflow
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr_ptr   <= {PW{1'b0}};
         r_grant    <= {PW{1'b0}};
         r_hold     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (|w_drop) r_overflow <= 1'b1;
         if (flush_i) begin
            r_rr_ptr <= {PW{1'b0}};
            r_hold   <= 1'b0;
         end else if (w_fire) begin
            r_rr_ptr <= (w_grant == PW'(NR_PORTS - 1)) ? {PW{1'b0}} : (w_grant + PW'(1));
            r_hold   <= 1'b0;
         end else if (wb_valid_o) begin
            r_hold   <= 1'b1;
            r_grant  <= w_grant;
         end else begin
            r_hold   <= 1'b0;
         end
      end
   end

`ifdef WB_ARBITER_PERF_EN
   logic [31:0] r_stall_cnt;

   // Saturating count of cycles the scoreboard refuses a valid writeback
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stall_cnt <= 32'd0;
      end else if (wb_valid_o && !wb_ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`else
   assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic checked against a
// queue-based reference model of the arbitration rules.
module tb_wb_arbiter;
   localparam int NP    = 4;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [2:0]   tid;
      logic [63:0]  res;
      logic [128:0] exc;
   } ent_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 flush;
   logic [NP-1:0]        valid;
   logic [NP-1:0][2:0]   trans_id;
   logic [NP-1:0][63:0]  result;
   logic [NP-1:0][128:0] exc;
   logic                 wb_ready;
   logic [NP-1:0]        port_ready_o;
   logic                 wb_valid_o;
   logic [2:0]           wb_trans_id_o;
   logic [63:0]          wb_result_o;
   logic [128:0]         wb_exception_o;
   logic                 overflow_o;
   logic [31:0]          stall_cnt_o;

   int checks   = 0;
   int failures = 0;

   // reference model state
   ent_t q [NP][$];
   int   m_rr;
   int   m_locked;
   bit   m_ovf;
   int   m_stall;

   wb_arbiter #(.NR_PORTS(NP), .DEPTH(DEPTH), .TRANS_ID_BITS(3), .EXC_BITS(129)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .flush_i       (flush),
      .valid_i       (valid),
      .trans_id_i    (trans_id),
      .result_i      (result),
      .exception_i   (exc),
      .port_ready_o  (port_ready_o),
      .wb_valid_o    (wb_valid_o),
      .wb_ready_i    (wb_ready),
      .wb_trans_id_o (wb_trans_id_o),
      .wb_result_o   (wb_result_o),
      .wb_exception_o(wb_exception_o),
      .overflow_o    (overflow_o),
      .stall_cnt_o   (stall_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < NP; i++) q[i].delete();
      m_rr = 0; m_locked = -1; m_ovf = 1'b0; m_stall = 0;
   endtask

   function automatic int m_grant();
      int g;
      g = -1;
      if (m_locked >= 0) g = m_locked;
      else for (int k = 0; k < NP; k++)
         if (g < 0 && q[(m_rr + k) % NP].size() > 0) g = (m_rr + k) % NP;
      return g;
   endfunction

   task automatic rand_data();
      for (int i = 0; i < NP; i++) begin
         trans_id[i] = 3'($urandom());
         result[i]   = {$urandom(), $urandom()};
         exc[i]      = {1'($urandom()), $urandom(), $urandom(), $urandom(), $urandom()};
      end
   endtask

   // One clock: drive, compare outputs with the model, clock edge, advance the model.
   task automatic cycle(input logic [NP-1:0] v, input logic rdy, input logic fl);
      int   gp;
      ent_t e;
      logic [31:0] exp_stall;
      valid = v; wb_ready = rdy; flush = fl;
      #2;
      gp = m_grant();
      chk("wb_valid", wb_valid_o, gp >= 0);
      if (gp >= 0) begin
         e = q[gp][0];
         chk("wb_trans_id", wb_trans_id_o, e.tid);
         chk("wb_result", wb_result_o, e.res);
         chk("wb_exception", wb_exception_o, e.exc);
      end
      for (int i = 0; i < NP; i++) chk("port_ready", port_ready_o[i], q[i].size() <= DEPTH - 2);
      chk("overflow", overflow_o, m_ovf);
`ifdef WB_ARBITER_PERF_EN
      exp_stall = 32'(m_stall);
`else
      exp_stall = 32'd0;
`endif
      chk("stall_cnt", stall_cnt_o, exp_stall);
      @(posedge clk);
      if (gp >= 0 && !rdy) m_stall++;
      if (fl) begin
         for (int i = 0; i < NP; i++) q[i].delete();
         m_rr = 0; m_locked = -1;
      end else begin
         if (gp >= 0 && rdy) begin
            void'(q[gp].pop_front());
            m_rr = (gp + 1) % NP; m_locked = -1;
         end else begin
            m_locked = gp;
         end
         for (int i = 0; i < NP; i++) if (v[i]) begin
            if (q[i].size() < DEPTH) begin
               e.tid = trans_id[i]; e.res = result[i]; e.exc = exc[i];
               q[i].push_back(e);
            end else m_ovf = 1'b1;
         end
      end
      #1;
   endtask

   initial begin
      int drained;
      rst_n = 1'b0; flush = 1'b0; valid = '0; wb_ready = 1'b0;
      rand_data();
      m_reset();
      @(posedge clk); #1;
      chk("rst_wb_valid", wb_valid_o, 1'b0);
      chk("rst_port_ready", port_ready_o, 4'hF);
      chk("rst_overflow", overflow_o, 1'b0);
      chk("rst_stall", stall_cnt_o, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // single push on port 2
      trans_id[2] = 3'd5; result[2] = 64'hDEAD;
      cycle(4'b0100, 1'b1, 1'b0);
      chk("single_valid", wb_valid_o, 1'b1);
      chk("single_tid", wb_trans_id_o, 3'd5);
      chk("single_res", wb_result_o, 64'hDEAD);
      cycle(4'b0000, 1'b1, 1'b0);
      chk("single_low", wb_valid_o, 1'b0);

      // all ports at once from rr_ptr 0
      cycle(4'b0000, 1'b1, 1'b1);
      rand_data();
      for (int i = 0; i < NP; i++) trans_id[i] = 3'(i);
      cycle(4'b1111, 1'b1, 1'b0);
      for (int g = 0; g < NP; g++) begin
         chk("rr_order", wb_trans_id_o, 3'(g));
         cycle(4'b0000, 1'b1, 1'b0);
      end
      chk("rr_done", wb_valid_o, 1'b0);

      // overflow on port 0
      for (int n = 1; n <= 3; n++) begin
         rand_data(); trans_id[0] = 3'(n);
         cycle(4'b0001, 1'b0, 1'b0);
         if (n == 1) chk("ovf_port_ready0", port_ready_o[0], 1'b0);
         if (n == 2) chk("ovf_not_yet", overflow_o, 1'b0);
      end
      chk("ovf_set", overflow_o, 1'b1);
      drained = 0;
      for (int n = 0; n < 4; n++) begin
         if (wb_valid_o) drained++;
         cycle(4'b0000, 1'b1, 1'b0);
      end
      chk("ovf_drained", drained, 2);

      // flush with 3 buffered entries plus a same-cycle push
      rand_data();
      cycle(4'b1110, 1'b0, 1'b0);
      rand_data();
      cycle(4'b0001, 1'b0, 1'b1);
      chk("flush_empty", wb_valid_o, 1'b0);
      for (int n = 0; n < 3; n++) cycle(4'b0000, 1'b1, 1'b0);
      chk("flush_sticky_ovf", overflow_o, 1'b1);

      // reset mid-drain
      rand_data();
      cycle(4'b1111, 1'b0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b0);
      #2; rst_n = 1'b0; #1;
      m_reset();
      chk("mid_rst_valid", wb_valid_o, 1'b0);
      chk("mid_rst_ready", port_ready_o, 4'hF);
      chk("mid_rst_ovf", overflow_o, 1'b0);
      chk("mid_rst_stall", stall_cnt_o, 32'd0);
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      for (int n = 0; n < 3; n++) cycle(4'b0000, 1'b1, 1'b0);

      // 7-cycle stall with a pending entry on port 3
      rand_data(); trans_id[3] = 3'd6; result[3] = 64'h0123_4567_89AB_CDEF;
      cycle(4'b1000, 1'b0, 1'b0);
      for (int n = 0; n < 7; n++) begin
         rand_data();
         cycle(4'b0000, 1'b0, 1'b0);
         chk("stall_tid", wb_trans_id_o, 3'd6);
         chk("stall_res", wb_result_o, 64'h0123_4567_89AB_CDEF);
      end
`ifdef WB_ARBITER_PERF_EN
      chk("stall_cnt7", stall_cnt_o, 32'd7);
`else
      chk("stall_cnt_off", stall_cnt_o, 32'd0);
`endif

      // random traffic
      for (int n = 0; n < 400; n++) begin
         rand_data();
         cycle(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3));
      end
      for (int n = 0; n < 10; n++) cycle(4'b0000, 1'b1, 1'b0);
      chk("final_empty", wb_valid_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NR_PORTS, default 4, number of writeback source ports (FLU, load, store, FPU).
REQ-002 SHALL have parameter DEPTH, default 2, entries per port FIFO, power of two, minimum 2.
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discard all buffered results.
REQ-006 SHALL have port valid_i  input  NR_PORTS  per-port result valid (single-cycle pulse, no backpressure).
REQ-007 SHALL have port trans_id_i  input  NR_PORTS x TRANS_ID_BITS  scoreboard entry per port.
REQ-008 SHALL have port result_i  input  NR_PORTS x 64  result data per port.
REQ-009 SHALL have port exception_i  input  NR_PORTS x exception_t  exception per port.
REQ-010 SHALL have port port_ready_o  output  NR_PORTS  port FIFO has at least 2 free entries (issue-stall hint).
REQ-011 SHALL have port wb_valid_o  output  1  writeback valid toward scoreboard.
REQ-012 SHALL have port wb_ready_i  input  1  scoreboard accepts writeback this cycle.
REQ-013 SHALL have port wb_trans_id_o  output  TRANS_ID_BITS  granted entry id.
REQ-014 SHALL have port wb_result_o  output  64  granted result.
REQ-015 SHALL have port wb_exception_o  output  exception_t  granted exception.
REQ-016 SHALL have port overflow_o  output  1  sticky: a result was dropped.
REQ-017 SHALL have port stall_cnt_o  output  32  backpressure stall cycles.

Function
REQ-018 SHALL buffer each port in its own DEPTH-entry FIFO (wrapping read/write pointers plus count).
REQ-019 SHALL write {trans_id, result, exception} into port i FIFO on the clock edge where valid_i[i]=1.
REQ-020 SHALL make an entry eligible for grant the cycle after it is written; input-to-wb_valid_o latency is exactly 1 cycle when uncontended.
REQ-021 SHALL assert wb_valid_o whenever any FIFO is non-empty and drive wb_* combinationally from the granted FIFO head.
REQ-022 SHALL grant round-robin: first non-empty port at or after rr_ptr, wrapping at NR_PORTS-1 -> 0.
REQ-023 SHALL pop the granted head and set rr_ptr to grant+1 (mod NR_PORTS) only when wb_valid_o & wb_ready_i.
REQ-024 SHALL hold grant, rr_ptr and wb_* stable while wb_valid_o & !wb_ready_i.
REQ-025 SHALL accept a push to a full FIFO when that same FIFO is popped that cycle.
REQ-026 SHALL drop a push to a full FIFO that is not popped, and set overflow_o the next cycle, held until reset.
REQ-027 SHALL, on flush_i, empty all FIFOs and reset rr_ptr to 0 on that edge; same-cycle pushes are discarded; overflow_o is not cleared.
REQ-028 SHALL deassert port_ready_o[i] when the FIFO count is greater than DEPTH-2.

Reset
REQ-029 SHALL, while rst_ni=0, clear all FIFOs, rr_ptr=0, overflow_o=0, stall_cnt_o=0, giving wb_valid_o=0 and port_ready_o all-ones.
REQ-030 SHALL, on reset assertion mid-transfer, abandon buffered entries with no writeback emitted.

Configuration
REQ-031 SHALL, with WB_ARBITER_PERF_EN defined, increment stall_cnt_o each cycle wb_valid_o & !wb_ready_i, saturating at 32'hFFFF_FFFF, unaffected by flush_i.
REQ-032 SHALL, without WB_ARBITER_PERF_EN, tie stall_cnt_o to 0 and contain no counter register.

Verification
REQ-033 SHALL cover: single push on port 2 (trans_id 5, result 64'hDEAD) with wb_ready_i=1 -> wb_valid_o one cycle later with trans_id 5, result 64'hDEAD, then low.
REQ-034 SHALL cover: all 4 ports push together, rr_ptr=0, wb_ready_i=1 -> grants 0,1,2,3 in 4 consecutive cycles.
REQ-035 SHALL cover: port 0 gets 3 pushes with wb_ready_i=0 (DEPTH=2) -> port_ready_o[0]=0 after first push, overflow_o=1 after third, only 2 entries drained after ready.
REQ-036 SHALL cover: flush_i with 3 buffered entries plus a same-cycle push -> wb_valid_o=0 next cycle, no entry emitted later.
REQ-037 SHALL cover: wb_ready_i=0 for 7 cycles with a pending entry, WB_ARBITER_PERF_EN defined -> stall_cnt_o=7, wb_* stable throughout.
REQ-038 SHALL cover: rst_ni low mid-drain -> all outputs at reset values; after release no stale writeback.
